adc_matrix_decoder_dem: RTL and testbench
=========================================

Name: adc_matrix_decoder_dem

Overview:
- Parametrised, pipelined successor of the capacitor-matrix binary-to-inverted-thermometer decoder.
- Converts a SAR DAC code into row, row-on, column and binary-capacitor enables for a 2^ROW_BITS x 2^COL_BITS unit matrix.
- Registers the result with a two-stage pipeline.
- Optionally applies row-level dynamic element matching (DEM): a rotating row pointer spreads unit-cap mismatch across conversions.
- Sits between the SAR logic and the capacitor-array drivers.

Parameters:
- ROW_BITS, 4, row-index bits; ROWS = 2^ROW_BITS.
- COL_BITS, 5, column-index bits; COLS = 2^COL_BITS.
- BIN_BITS, 3, binary-weighted LSB capacitors; W = ROW_BITS+COL_BITS+BIN_BITS.

Ports:
- clk  in  1  decoder clock
- rst_n  in  1  asynchronous active-low reset
- load_i  in  1  accept data_i this cycle
- data_i  in  W  DAC code: [W-1:COL_BITS+BIN_BITS]=row, [COL_BITS+BIN_BITS-1:BIN_BITS]=col, [BIN_BITS-1:0]=bincap
- dem_en_i  in  1  advance row pointer on each load
- ptr_clr_i  in  1  synchronous pointer clear
- row_out_n  out  ROWS  full-row enables, active low
- rowon_out_n  out  ROWS  partial-row enables, active low
- col_out_n  out  COLS  column enables for partial row, active low
- bincap_out_n  out  BIN_BITS  binary caps, active low
- c0p_out_n  out  1  constant 1
- c0n_out_n  out  1  constant 0
- valid_o  out  1  outputs updated this cycle
- ptr_o  out  ROW_BITS  current DEM pointer

Behaviour:
- Decode (logical, r=row field, c=col field):
  - row_l_n = ({ROWS{1}} with bit0=0) << r
  - rowon_l_n = {1, row_l_n[ROWS-1:1]}
  - col_out_n = r odd ? ({COLS{1}} >> 1) >> c : ({COLS{1}} with bit0=0) << c
  - bincap_out_n = ~bincap
- DEM: row_out_n = rotl(row_l_n, P) and rowon_out_n = rotl(rowon_l_n, P), rotation modulo ROWS.
  - col_out_n and bincap_out_n are not rotated.
  - Column snake direction follows the logical row parity.
- Pipeline:
  - Stage 1 registers data_i and the current P on load_i=1.
  - Stage 2 registers the decoded outputs one cycle later.
  - Latency is 2 cycles from load_i to outputs; valid_o pulses high in the same cycle the outputs change.
  - Back-to-back loads are accepted every cycle.
  - With no load, outputs hold their last value.
- Pointer P (ROW_BITS bits):
  - On load_i=1 with dem_en_i=1: P <= P+1, wrapping ROWS-1 -> 0.
  - With dem_en_i=0: P holds.
  - ptr_clr_i=1 sets P <= 0 and has priority over increment.
  - A load in the same cycle as a clear uses the pre-clear P.
- Reset (async assert, sync release):
  - P=0, valid_o=0, stage registers zero.
  - Outputs equal the decode of code 0 with P=0: row_out_n={1..1,0}, rowon_out_n=all 1, col_out_n={1..1,0}, bincap_out_n=all 1.
- Reset mid-pipeline discards in-flight codes; no valid_o is issued for them.
- c0p_out_n/c0n_out_n are constants, unaffected by reset.

Optional Feature:
- Macro ADC_DECODER_DEM_EN.
- Defined: pointer logic and rotation exist as above.
- Undefined:
  - P is a constant 0 and ptr_o reads 0.
  - dem_en_i and ptr_clr_i are ignored.
  - Outputs equal the unrotated decode.
  - Latency, valid_o and reset values are unchanged.

Test Plan:
- Reset, defaults -> row_out_n=16'hFFFE, rowon_out_n=16'hFFFF, col_out_n=32'hFFFFFFFE, bincap_out_n=3'b111, valid_o=0, ptr_o=0.
- load_i=1, data_i=12'h10B, dem_en_i=0 -> 2 cycles later valid_o=1, row_out_n=16'hFFFC, rowon_out_n=16'hFFFE, col_out_n=32'h3FFFFFFF, bincap_out_n=3'b100; ptr_o stays 0.
- dem_en_i=1, three loads of 12'h000, then load 12'h10B -> ptr_o=3 at the 4th load; row_out_n=16'hFFE7, rowon_out_n=16'hFFF7; ptr_o=4 afterwards.
- dem_en_i=1, 16 consecutive loads from P=15 -> P wraps 15->0; row_out_n for code 0 at P=15 is 16'h7FFF; valid_o high 16 consecutive cycles.
- ptr_clr_i and load_i asserted together at P=5 -> that code is rotated by 5; ptr_o=0 the next cycle.
- rst_n low one cycle after a load -> no valid_o pulse; outputs return to reset values immediately.

Source files
------------

// File: rtl/adc_matrix_decoder_dem.sv
// rtl/adc_matrix_decoder_dem.sv - pipelined SAR code to cap-matrix enable decoder with optional row DEM
// Row DEM rotation is built only when ADC_DECODER_DEM_EN is defined; otherwise the pointer is fixed at 0.
module adc_matrix_decoder_dem #(
   parameter  int ROW_BITS = 4,
   parameter  int COL_BITS = 5,
   parameter  int BIN_BITS = 3,
   localparam int ROWS     = 1 << ROW_BITS,
   localparam int COLS     = 1 << COL_BITS,
   localparam int W        = ROW_BITS + COL_BITS + BIN_BITS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_i,
   input  logic [W-1:0]        data_i,
   input  logic                dem_en_i,
   input  logic                ptr_clr_i,
   output logic [ROWS-1:0]     row_out_n,
   output logic [ROWS-1:0]     rowon_out_n,
   output logic [COLS-1:0]     col_out_n,
   output logic [BIN_BITS-1:0] bincap_out_n,
   output logic                c0p_out_n,
   output logic                c0n_out_n,
   output logic                valid_o,
   output logic [ROW_BITS-1:0] ptr_o
);

   localparam logic [ROWS-1:0] ROW_ONE0 = {{(ROWS-1){1'b1}}, 1'b0};
   localparam logic [COLS-1:0] COL_ONE0 = {{(COLS-1){1'b1}}, 1'b0};
   localparam logic [COLS-1:0] COL_ALL1 = {COLS{1'b1}};

   function automatic logic [ROWS-1:0] rotl(input logic [ROWS-1:0] x,
                                            input logic [ROW_BITS-1:0] p);
      logic [2*ROWS-1:0] t;
      t = {x, x} << p;
      return t[2*ROWS-1:ROWS];
   endfunction

   logic [ROW_BITS-1:0] ptr_cur;

`ifdef ADC_DECODER_DEM_EN
   logic [ROW_BITS-1:0] ptr_q, ptr_d;

   // Clear wins over advance; a load alongside a clear still captures the old pointer.
   always_comb begin
      ptr_d = ptr_q;
      if (ptr_clr_i)
         ptr_d = '0;
      else if (load_i && dem_en_i)
         ptr_d = ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr_q <= '0;
      else
         ptr_q <= ptr_d;
   end

   assign ptr_cur = ptr_q;
`else
   logic unused_dem_inputs;
   assign unused_dem_inputs = dem_en_i | ptr_clr_i;
   assign ptr_cur = '0;
`endif

   assign ptr_o = ptr_cur;

   // Stage 1: captured code and the pointer it will be rotated by.
   logic [W-1:0]        data_q;
   logic [ROW_BITS-1:0] sptr_q;
   logic                s1_vld_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q   <= '0;
         sptr_q   <= '0;
         s1_vld_q <= 1'b0;
      end else begin
         s1_vld_q <= load_i;
         if (load_i) begin
            data_q <= data_i;
            sptr_q <= ptr_cur;
         end
      end
   end

   logic [ROW_BITS-1:0] row_f;
   logic [COL_BITS-1:0] col_f;
   logic [BIN_BITS-1:0] bin_f;
   logic [ROWS-1:0]     row_l, rowon_l, row_d, rowon_d;
   logic [COLS-1:0]     col_d;
   logic [BIN_BITS-1:0] bin_d;

   assign row_f = data_q[W-1 -: ROW_BITS];
   assign col_f = data_q[BIN_BITS +: COL_BITS];
   assign bin_f = data_q[BIN_BITS-1:0];

   // Columns snake: odd logical rows fill from the top, even rows from the bottom.
   always_comb begin
      row_l   = ROW_ONE0 << row_f;
      rowon_l = {1'b1, row_l[ROWS-1:1]};
      row_d   = rotl(row_l, sptr_q);
      rowon_d = rotl(rowon_l, sptr_q);
      col_d   = row_f[0] ? ((COL_ALL1 >> 1) >> col_f) : (COL_ONE0 << col_f);
      bin_d   = ~bin_f;
   end

   // Stage 2: driver-facing registers, held between loads.
   logic [ROWS-1:0]     row_q, rowon_q;
   logic [COLS-1:0]     col_q;
   logic [BIN_BITS-1:0] bin_q;
   logic                vld_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q   <= ROW_ONE0;
         rowon_q <= {ROWS{1'b1}};
         col_q   <= COL_ONE0;
         bin_q   <= {BIN_BITS{1'b1}};
         vld_q   <= 1'b0;
      end else begin
         vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            row_q   <= row_d;
            rowon_q <= rowon_d;
            col_q   <= col_d;
            bin_q   <= bin_d;
         end
      end
   end

   assign row_out_n    = row_q;
   assign rowon_out_n  = rowon_q;
   assign col_out_n    = col_q;
   assign bincap_out_n = bin_q;
   assign valid_o      = vld_q;
   assign c0p_out_n    = 1'b1;
   assign c0n_out_n    = 1'b0;

endmodule

// File: tb/tb_adc_matrix_decoder_dem.sv
// tb/tb_adc_matrix_decoder_dem.sv - directed bench for adc_matrix_decoder_dem
module tb_adc_matrix_decoder_dem;

`ifdef ADC_DECODER_DEM_EN
   localparam bit DEM = 1'b1;
`else
   localparam bit DEM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_i;
   logic [11:0] data_i;
   logic        dem_en_i;
   logic        ptr_clr_i;
   logic [15:0] row_out_n;
   logic [15:0] rowon_out_n;
   logic [31:0] col_out_n;
   logic [2:0]  bincap_out_n;
   logic        c0p_out_n;
   logic        c0n_out_n;
   logic        valid_o;
   logic [3:0]  ptr_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   adc_matrix_decoder_dem dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (load_i),
      .data_i       (data_i),
      .dem_en_i     (dem_en_i),
      .ptr_clr_i    (ptr_clr_i),
      .row_out_n    (row_out_n),
      .rowon_out_n  (rowon_out_n),
      .col_out_n    (col_out_n),
      .bincap_out_n (bincap_out_n),
      .c0p_out_n    (c0p_out_n),
      .c0n_out_n    (c0n_out_n),
      .valid_o      (valid_o),
      .ptr_o        (ptr_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] row, input logic [15:0] rowon,
                          input logic [31:0] col, input logic [2:0] bin);
      chk({tag, ".row"},   row_out_n,    row);
      chk({tag, ".rowon"}, rowon_out_n,  rowon);
      chk({tag, ".col"},   col_out_n,    col);
      chk({tag, ".bin"},   bincap_out_n, bin);
   endtask

   initial begin
      logic [15:0] e;
      rst_n = 1'b0; load_i = 1'b0; data_i = '0; dem_en_i = 1'b0; ptr_clr_i = 1'b0;
      tick(); tick();
      chk_out("reset", 16'hFFFE, 16'hFFFF, 32'hFFFFFFFE, 3'b111);
      chk("reset.valid", valid_o, 0);
      chk("reset.ptr", ptr_o, 0);
      chk("c0p", c0p_out_n, 1);
      chk("c0n", c0n_out_n, 0);
      rst_n = 1'b1;
      tick();

      // Single load, odd row, no DEM
      load_i = 1'b1; data_i = 12'h10B;
      tick();
      load_i = 1'b0;
      chk("lat1.valid", valid_o, 0);
      tick();
      chk("lat2.valid", valid_o, 1);
      chk_out("code10B", 16'hFFFC, 16'hFFFE, 32'h3FFFFFFF, 3'b100);
      chk("code10B.ptr", ptr_o, 0);
      tick();
      chk("hold.valid", valid_o, 0);
      chk("hold.row", row_out_n, 16'hFFFC);

      // Even row snake and row/col upper boundary, back to back
      load_i = 1'b1; data_i = 12'h21D;
      tick();
      data_i = 12'hFF8;
      tick();
      load_i = 1'b0;
      chk("b2b0.valid", valid_o, 1);
      chk_out("code21D", 16'hFFF8, 16'hFFFC, 32'hFFFFFFF0, 3'b010);
      tick();
      chk("b2b1.valid", valid_o, 1);
      chk_out("codeFF8", 16'h0000, 16'h8000, 32'h00000000, 3'b111);
      tick();

      // DEM: three zero loads then 0x10B at pointer 3
      dem_en_i = 1'b1; load_i = 1'b1; data_i = 12'h000;
      repeat (3) tick();
      chk("dem.ptr3", ptr_o, DEM ? 3 : 0);
      data_i = 12'h10B;
      tick();
      load_i = 1'b0;
      chk("dem.ptr4", ptr_o, DEM ? 4 : 0);
      tick();
      chk("dem.valid", valid_o, 1);
      chk_out("dem10B", DEM ? 16'hFFE7 : 16'hFFFC, DEM ? 16'hFFF7 : 16'hFFFE, 32'h3FFFFFFF, 3'b100);
      tick();

      // Move pointer to 15, drain, then 16 consecutive loads across the wrap
      ptr_clr_i = 1'b1;
      tick();
      ptr_clr_i = 1'b0; load_i = 1'b1; data_i = 12'h000;
      repeat (15) tick();
      load_i = 1'b0;
      chk("wrap.ptr15", ptr_o, DEM ? 15 : 0);
      repeat (3) tick();
      for (int i = 0; i < 16; i++) begin
         load_i = 1'b1;
         tick();
         if (i == 0) begin
            chk("wrap.idle_valid", valid_o, 0);
            chk("wrap.ptr0", ptr_o, 0);
         end else begin
            e = DEM ? ~(16'h1 << ((14 + i) % 16)) : 16'hFFFE;
            chk($sformatf("wrap%0d.valid", i), valid_o, 1);
            chk($sformatf("wrap%0d.row", i), row_out_n, e);
         end
      end
      load_i = 1'b0;
      tick();
      chk("wrap15.valid", valid_o, 1);
      chk("wrap15.row", row_out_n, DEM ? 16'hBFFF : 16'hFFFE);
      tick();
      chk("wrap.end_valid", valid_o, 0);
      chk("wrap.end_ptr", ptr_o, DEM ? 15 : 0);

      // Clear coinciding with a load at pointer 5
      ptr_clr_i = 1'b1;
      tick();
      ptr_clr_i = 1'b0; load_i = 1'b1; data_i = 12'h000;
      repeat (5) tick();
      load_i = 1'b0;
      repeat (3) tick();
      chk("clr.ptr5", ptr_o, DEM ? 5 : 0);
      load_i = 1'b1; data_i = 12'h10B; ptr_clr_i = 1'b1;
      tick();
      load_i = 1'b0; ptr_clr_i = 1'b0;
      chk("clr.ptr0", ptr_o, 0);
      tick();
      chk("clr.valid", valid_o, 1);
      chk_out("clr10B", DEM ? 16'hFF9F : 16'hFFFC, DEM ? 16'hFFDF : 16'hFFFE, 32'h3FFFFFFF, 3'b100);
      tick();

      // Reset with a code in flight
      load_i = 1'b1; data_i = 12'h10B;
      tick();
      load_i = 1'b0;
      chk("rst.ptr_pre", ptr_o, DEM ? 1 : 0);
      rst_n = 1'b0;
      #1;
      chk_out("rst_mid", 16'hFFFE, 16'hFFFF, 32'hFFFFFFFE, 3'b111);
      chk("rst_mid.valid", valid_o, 0);
      chk("rst_mid.ptr", ptr_o, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_post1.valid", valid_o, 0);
      tick();
      chk("rst_post2.valid", valid_o, 0);
      chk("rst_post2.row", row_out_n, 16'hFFFE);
      chk("rst_post.c0p", c0p_out_n, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
